// File: rtl/evm_pkg.sv
// evm_pkg: ballot controller state encoding and one-hot helpers.
package evm_pkg;
   typedef enum logic [1:0] {IDLE, ARMED, COMMIT, LOCK} state_t;
   localparam int MAX_CAND = 16;
   function automatic logic is_onehot(input logic [MAX_CAND-1:0] v);
      return v != '0 && (v & (v - MAX_CAND'(1))) == '0;
   endfunction
   function automatic logic [3:0] onehot_idx(input logic [MAX_CAND-1:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_CAND; i++) if (v[i]) idx = 4'(i);
      return idx;
   endfunction
endpackage

// File: rtl/evm_tally_bank.sv
// evm_tally_bank: per-candidate saturating vote counters with sticky saturation flags.
module evm_tally_bank #(
   parameter int N_CAND = 4,
   parameter int CNT_W  = 8,
   parameter int IDX_W  = $clog2(N_CAND)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    inc_en,
   input  logic [IDX_W-1:0]        inc_idx,
   input  logic                    clr,
   output logic [N_CAND*CNT_W-1:0] tally,
   output logic [N_CAND-1:0]       sat
);
   for (genvar i = 0; i < N_CAND; i++) begin : g_cnt
      logic [CNT_W-1:0] cnt;
      logic             s;
      logic             hit;
      assign hit = inc_en && inc_idx == IDX_W'(i);
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt <= '0;
            s   <= 1'b0;
         end else if (clr) begin
            cnt <= '0;
            s   <= 1'b0;
         end else if (hit) begin
            cnt <= &cnt ? cnt : cnt + CNT_W'(1);
            s   <= s | (&cnt);
         end
      end
      assign tally[i*CNT_W +: CNT_W] = cnt;
      assign sat[i] = s;
   end
endmodule

// File: rtl/evm_ballot_ctrl.sv
// evm_ballot_ctrl: one-voter-at-a-time ballot sequencer with press arbitration,
// arming timeout and post-vote lockout in front of the tally bank.
module evm_ballot_ctrl
   import evm_pkg::*;
#(
   parameter int N_CAND      = 4,
   parameter int CNT_W       = 8,
   parameter int LOCK_CYC    = 16,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ballot_en,
   input  logic                      clear_tally,
   input  logic [N_CAND-1:0]         cand_btn,
   output logic                      armed,
   output logic                      vote_valid,
   output logic [$clog2(N_CAND)-1:0] vote_idx,
   output logic                      timeout,
   output logic [N_CAND*CNT_W-1:0]   tally,
   output logic [N_CAND-1:0]         sat
);
   localparam int IDX_W = $clog2(N_CAND);
   localparam int TW    = $clog2(TIMEOUT_CYC + 1);
   localparam int LW    = $clog2(LOCK_CYC + 1);
   state_t            state, state_nx;
   logic [N_CAND-1:0] btn_q, rise;
   logic [TW-1:0]     timer, timer_nx;
   logic [LW-1:0]     lock_cnt, lock_nx;
   logic              blocked, blocked_nx, accept, expire, lock_done;
   // blocked: an ambiguous press was seen; nothing counts until all buttons are released
   always_comb begin
      rise       = cand_btn & ~btn_q;
      accept     = !blocked && is_onehot(MAX_CAND'(rise)) && cand_btn == rise;
      expire     = timer == TW'(TIMEOUT_CYC - 1);
      lock_done  = lock_cnt == LW'(LOCK_CYC - 1);
      state_nx   = state;
      timer_nx   = '0;
      lock_nx    = '0;
      blocked_nx = 1'b0;
      case (state)
         IDLE: state_nx = ballot_en && cand_btn == '0 ? ARMED : IDLE;
         ARMED: begin
            timer_nx   = timer + TW'(1);
            blocked_nx = (blocked || (rise != '0 && !accept)) && cand_btn != '0;
            state_nx   = accept ? COMMIT : expire ? IDLE : ARMED;
         end
         COMMIT: state_nx = LOCK;
         default: begin
            lock_nx  = lock_done ? lock_cnt : lock_cnt + LW'(1);
            state_nx = lock_done && cand_btn == '0 ? IDLE : LOCK;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         btn_q      <= '0;
         timer      <= '0;
         lock_cnt   <= '0;
         blocked    <= 1'b0;
         vote_valid <= 1'b0;
         timeout    <= 1'b0;
         vote_idx   <= '0;
      end else begin
         state      <= state_nx;
         btn_q      <= cand_btn;
         timer      <= timer_nx;
         lock_cnt   <= lock_nx;
         blocked    <= blocked_nx;
         vote_valid <= state == COMMIT;
         timeout    <= state == ARMED && !accept && expire;
         if (state == ARMED && accept) vote_idx <= IDX_W'(onehot_idx(MAX_CAND'(rise)));
      end
   end
   assign armed = state == ARMED;
   evm_tally_bank #(.N_CAND(N_CAND), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_en  (state == COMMIT),
      .inc_idx (vote_idx),
      .clr     (state == IDLE && clear_tally),
      .tally   (tally),
      .sat     (sat)
   );
endmodule
